subsystem_stream_unpack: RTL and testbench

Receive-side counterpart of the ADC streaming subsystem. It consumes the 64-bit packetized stream (tfirst/tlast framed, header + timestamp + payload) and validates the framing. It unpacks the payload back into either individual 32-bit sample words (dual/single-channel modes) or full 16-channel sample sets (all-channel mode). It sits after the stream FIFO / link receiver and feeds the checker, histogramming and loopback-test logic.

---
 rtl/subsystem_stream_unpack.sv | 177 +++++++++++++++++
 tb/tb_subsystem_stream_unpack.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/subsystem_stream_unpack.sv
// subsystem_stream_unpack: validates header/ts/payload framing and unpacks payload into 32-bit words or 16-channel sets
module subsystem_stream_unpack #(
  parameter int NUM_CH = 16,
  parameter logic [7:0] PKT_ID = 8'hDD,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 all_chan,
  input  logic [63:0]          s_tdata,
  input  logic                 s_tfirst,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [17:0]          w_sample,
  output logic [2:0]           w_block,
  output logic [6:0]           w_rate_div,
  output logic [3:0]           w_ch,
  output logic                 w_valid,
  output logic [NUM_CH*18-1:0] set_data,
  output logic                 set_valid,
  output logic [63:0]          pkt_ts,
  output logic                 pkt_ts_valid,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int C15 = (NUM_CH - 1) * 18;
  typedef enum logic [1:0] {IDLE, TS, PAYLOAD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [15:0] n_q, n_d, cnt_q, cnt_d;
  logic ac_q, ac_d, pkt_bad_q, pkt_bad_d, set_bad_q, set_bad_d, lo_pend_q, lo_pend_d;
  logic [2:0] k_q, k_d;
  logic [31:0] lo_q, lo_d, w_q, w_d;
  logic [NUM_CH*18-1:0] acc_q, acc_d, set_q, set_d;
  logic w_valid_q, w_valid_d, set_valid_q, set_valid_d, ts_valid_q, ts_valid_d;
  logic [63:0] ts_q, ts_d;
  logic [CNT_W-1:0] pkt_q, pkt_d, err_q, err_d;
  logic acc, hdr_ok, last_beat, kerr, err_inc, pkt_inc;
  logic [8:0] base;
  always_comb begin
    acc = s_tvalid && s_tready;
    hdr_ok = s_tdata[63:56] == PKT_ID;
    last_beat = cnt_q + 16'd1 == n_q;
    kerr = ac_q && k_q != 3'd4;
    base = {6'd0, k_q} * 9'd54;
    state_d = state_q;
    n_d = n_q;
    cnt_d = cnt_q;
    ac_d = ac_q;
    pkt_bad_d = pkt_bad_q;
    set_bad_d = set_bad_q;
    k_d = k_q;
    lo_d = lo_q;
    lo_pend_d = 1'b0;
    acc_d = acc_q;
    set_d = set_q;
    set_valid_d = 1'b0;
    ts_d = ts_q;
    ts_valid_d = 1'b0;
    err_inc = 1'b0;
    pkt_inc = 1'b0;
    w_d = lo_pend_q ? lo_q : w_q;
    w_valid_d = lo_pend_q;
    if (acc) begin
      if (state_q == IDLE || (state_q == PAYLOAD && s_tfirst)) begin
        err_inc = state_q == PAYLOAD;
        if (s_tfirst && hdr_ok) begin
          state_d = TS;
          n_d = s_tdata[55:40];
          ac_d = all_chan;
          k_d = 3'd0;
          cnt_d = 16'd0;
          pkt_bad_d = 1'b0;
          set_bad_d = 1'b0;
        end else if (s_tfirst) begin
          state_d = DRAIN;
          err_inc = 1'b1;
        end
      end else if (state_q == TS) begin
        ts_d = s_tdata;
        ts_valid_d = 1'b1;
        state_d = (s_tlast || n_q == 16'd0) ? IDLE : PAYLOAD;
        err_inc = s_tlast && n_q != 16'd0;
        pkt_inc = s_tlast && n_q == 16'd0;
      end else if (state_q == PAYLOAD) begin
        cnt_d = cnt_q + 16'd1;
        if (!ac_q) begin
          w_d = s_tdata[63:32];
          w_valid_d = 1'b1;
          lo_d = s_tdata[31:0];
          lo_pend_d = 1'b1;
        end else if (&s_tdata) begin
          k_d = 3'd1;
          set_bad_d = 1'b1;
          pkt_bad_d = 1'b1;
          err_inc = 1'b1;
        end else begin
          acc_d[base +: 54] = s_tdata[53:0];
          if (k_q == 3'd0) acc_d[C15 +: 8] = s_tdata[61:54];
          if (k_q == 3'd1) acc_d[C15 + 8 +: 8] = s_tdata[61:54];
          if (k_q == 3'd2) acc_d[C15 + 16 +: 2] = s_tdata[55:54];
          k_d = k_q == 3'd4 ? 3'd0 : k_q + 3'd1;
          if (k_q == 3'd4) begin
            set_valid_d = !set_bad_q;
            set_d = set_bad_q ? set_q : acc_d;
            set_bad_d = 1'b0;
          end
        end
        if (s_tlast) begin
          state_d = IDLE;
          err_inc = err_inc || !last_beat || kerr;
          pkt_inc = !err_inc && !pkt_bad_q;
        end else if (last_beat) begin
          state_d = DRAIN;
          err_inc = 1'b1;
        end
      end else if (s_tlast) begin
        state_d = IDLE;
      end
    end
    pkt_d = pkt_q + CNT_W'(pkt_inc && !(&pkt_q));
    err_d = err_q + CNT_W'(err_inc && !(&err_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      cnt_q <= '0;
      ac_q <= 1'b0;
      pkt_bad_q <= 1'b0;
      set_bad_q <= 1'b0;
      lo_pend_q <= 1'b0;
      k_q <= '0;
      lo_q <= '0;
      w_q <= '0;
      acc_q <= '0;
      set_q <= '0;
      w_valid_q <= 1'b0;
      set_valid_q <= 1'b0;
      ts_valid_q <= 1'b0;
      ts_q <= '0;
      pkt_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      ac_q <= ac_d;
      pkt_bad_q <= pkt_bad_d;
      set_bad_q <= set_bad_d;
      lo_pend_q <= lo_pend_d;
      k_q <= k_d;
      lo_q <= lo_d;
      w_q <= w_d;
      acc_q <= acc_d;
      set_q <= set_d;
      w_valid_q <= w_valid_d;
      set_valid_q <= set_valid_d;
      ts_valid_q <= ts_valid_d;
      ts_q <= ts_d;
      pkt_q <= pkt_d;
      err_q <= err_d;
    end
  end
  assign s_tready = !lo_pend_q;
  assign w_sample = w_q[31:14];
  assign w_block = w_q[13:11];
  assign w_rate_div = w_q[10:4];
  assign w_ch = w_q[3:0];
  assign w_valid = w_valid_q;
  assign set_data = set_q;
  assign set_valid = set_valid_q;
  assign pkt_ts = ts_q;
  assign pkt_ts_valid = ts_valid_q;
  assign pkt_cnt = pkt_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_subsystem_stream_unpack.sv
// tb_subsystem_stream_unpack: directed + randomized packets checked against a packet-level reference model
module tb_subsystem_stream_unpack;
  localparam int NUM_CH = 16;
  localparam int SW = NUM_CH * 18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic all_chan = 1'b0;
  logic [63:0] s_tdata = '0;
  logic s_tfirst = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0;
  logic s_tready, w_valid, set_valid, pkt_ts_valid;
  logic [17:0] w_sample;
  logic [2:0] w_block;
  logic [6:0] w_rate_div;
  logic [3:0] w_ch;
  logic [SW-1:0] set_data;
  logic [63:0] pkt_ts;
  logic [15:0] pkt_cnt, err_cnt;
  int total = 0, bad = 0, exp_pkt = 0, exp_err = 0, lowrdy = 0;
  logic [31:0] obs_w[$], exp_w[$];
  logic [SW-1:0] obs_s[$], exp_s[$];
  logic [63:0] obs_ts[$], exp_ts[$];
  logic [31:0] w0;
  logic [63:0] p, ts;

  always #5 clk = ~clk;

  subsystem_stream_unpack dut (
    .clk(clk), .rst(rst), .all_chan(all_chan), .s_tdata(s_tdata), .s_tfirst(s_tfirst),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready), .w_sample(w_sample),
    .w_block(w_block), .w_rate_div(w_rate_div), .w_ch(w_ch), .w_valid(w_valid),
    .set_data(set_data), .set_valid(set_valid), .pkt_ts(pkt_ts), .pkt_ts_valid(pkt_ts_valid),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always @(negedge clk) begin
    if (w_valid) obs_w.push_back({w_sample, w_block, w_rate_div, w_ch});
    if (set_valid) obs_s.push_back(set_data);
    if (pkt_ts_valid) obs_ts.push_back(pkt_ts);
    if (!s_tready) lowrdy++;
  end

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic send(input logic [63:0] d, input logic f, input logic l);
    int n = 0;
    s_tdata = d;
    s_tfirst = f;
    s_tlast = l;
    s_tvalid = 1'b1;
    while (!s_tready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) chk("tready_timeout", SW'(s_tready), SW'(1));
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] id, input logic [15:0] n);
    logic [63:0] r;
    r = r64();
    send({id, n, r[39:0]}, 1'b1, 1'b0);
  endtask

  task automatic word_pkt(input int n, input logic [63:0] t, input logic [63:0] p0);
    logic [63:0] d;
    all_chan = 1'b0;
    hdr(8'hDD, 16'(n));
    send(t, 1'b0, 1'b0);
    exp_ts.push_back(t);
    for (int i = 0; i < n; i++) begin
      d = i == 0 ? p0 : r64();
      send(d, 1'b0, i == n - 1);
      exp_w.push_back(d[63:32]);
      exp_w.push_back(d[31:0]);
    end
    exp_pkt++;
  endtask

  function automatic logic [63:0] ac_beat(input logic [17:0] c[16], input int k);
    logic [7:0] x;
    x = k == 0 ? c[15][7:0] : k == 1 ? c[15][15:8] : k == 2 ? {6'd0, c[15][17:16]} : 8'd0;
    return {2'b00, x, c[3*k+2], c[3*k+1], c[3*k]};
  endfunction

  task automatic ac_set(input bit fixed, input bit last, input int k0);
    logic [17:0] c[16];
    logic [SW-1:0] s;
    for (int i = 0; i < 16; i++) c[i] = fixed ? (i == 15 ? 18'h2A5A5 : 18'(i + 1)) : 18'($urandom());
    for (int i = 0; i < 16; i++) s[i*18 +: 18] = c[i];
    for (int k = k0; k < 5; k++) send(ac_beat(c, k), 1'b0, last && k == 4);
    if (k0 == 0) exp_s.push_back(s);
  endtask

  task automatic clear_q();
    obs_w.delete(); exp_w.delete(); obs_s.delete(); exp_s.delete(); obs_ts.delete(); exp_ts.delete();
  endtask

  task automatic settle(input string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_n_words"}, SW'(obs_w.size()), SW'(exp_w.size()));
    foreach (exp_w[i]) if (i < obs_w.size()) chk({tag, "_word"}, SW'(obs_w[i]), SW'(exp_w[i]));
    chk({tag, "_n_sets"}, SW'(obs_s.size()), SW'(exp_s.size()));
    foreach (exp_s[i]) if (i < obs_s.size()) chk({tag, "_set"}, obs_s[i], exp_s[i]);
    chk({tag, "_n_ts"}, SW'(obs_ts.size()), SW'(exp_ts.size()));
    foreach (exp_ts[i]) if (i < obs_ts.size()) chk({tag, "_ts"}, SW'(obs_ts[i]), SW'(exp_ts[i]));
    chk({tag, "_pkt_cnt"}, SW'(pkt_cnt), SW'(exp_pkt));
    chk({tag, "_err_cnt"}, SW'(err_cnt), SW'(exp_err));
    clear_q();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tready", SW'(s_tready), SW'(1));
    chk("rst_w_valid", SW'(w_valid), SW'(0));
    chk("rst_set_valid", SW'(set_valid), SW'(0));
    chk("rst_ts_valid", SW'(pkt_ts_valid), SW'(0));
    chk("rst_pkt_cnt", SW'(pkt_cnt), SW'(0));
    chk("rst_err_cnt", SW'(err_cnt), SW'(0));
    rst = 1'b0;
    @(negedge clk);
    lowrdy = 0;
    word_pkt(2, 64'h0123_4567_89AB_CDEF, 64'h0004_8123_0008_C456);
    repeat (4) @(negedge clk);
    w0 = obs_w.size() > 0 ? obs_w[0] : '0;
    chk("w0_sample", SW'(w0[31:14]), SW'(18'h12));
    chk("w0_block", SW'(w0[13:11]), SW'(3'd0));
    chk("w0_rate_div", SW'(w0[10:4]), SW'(7'h12));
    chk("w0_ch", SW'(w0[3:0]), SW'(4'd3));
    chk("tready_toggles", SW'(lowrdy >= 2), SW'(1));
    settle("word_plan");
    for (int r = 0; r < 3; r++) word_pkt($urandom_range(1, 4), r64(), r64());
    settle("word_rand");
    all_chan = 1'b1;
    ts = r64();
    hdr(8'hDD, 16'd10);
    send(ts, 1'b0, 1'b0);
    exp_ts.push_back(ts);
    ac_set(1'b1, 1'b0, 0);
    ac_set(1'b0, 1'b1, 0);
    exp_pkt++;
    settle("allchan");
    ts = r64();
    hdr(8'hDD, 16'd5);
    send(ts, 1'b0, 1'b0);
    exp_ts.push_back(ts);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    ac_set(1'b0, 1'b1, 1);
    exp_err++;
    settle("marker");
    all_chan = 1'b0;
    hdr(8'hDE, 16'd3);
    for (int i = 0; i < 3; i++) send(r64(), 1'b0, i == 2);
    exp_err++;
    settle("bad_id");
    word_pkt(1, r64(), r64());
    settle("after_bad_id");
    all_chan = 1'b1;
    ts = r64();
    hdr(8'hDD, 16'd3);
    send(ts, 1'b0, 1'b0);
    exp_ts.push_back(ts);
    p = r64();
    p[63:62] = 2'b00;
    send(p, 1'b0, 1'b1);
    exp_err++;
    settle("early_tlast");
    all_chan = 1'b0;
    ts = r64();
    hdr(8'hDD, 16'd1);
    send(ts, 1'b0, 1'b0);
    exp_ts.push_back(ts);
    p = r64();
    send(p, 1'b0, 1'b0);
    exp_w.push_back(p[63:32]);
    exp_w.push_back(p[31:0]);
    send(r64(), 1'b0, 1'b0);
    send(r64(), 1'b0, 1'b0);
    send(r64(), 1'b0, 1'b1);
    exp_err++;
    settle("missing_tlast");
    hdr(8'hDD, 16'd4);
    send(r64(), 1'b0, 1'b0);
    send(r64(), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_w_valid", SW'(w_valid), SW'(0));
    chk("mid_rst_w_sample", SW'(w_sample), SW'(0));
    chk("mid_rst_tready", SW'(s_tready), SW'(1));
    chk("mid_rst_pkt_ts", SW'(pkt_ts), SW'(0));
    chk("mid_rst_set_data", set_data, SW'(0));
    chk("mid_rst_pkt_cnt", SW'(pkt_cnt), SW'(0));
    chk("mid_rst_err_cnt", SW'(err_cnt), SW'(0));
    rst = 1'b0;
    clear_q();
    exp_pkt = 0;
    exp_err = 0;
    @(negedge clk);
    word_pkt(2, r64(), r64());
    settle("after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
